mem_arbiter: RTL and testbench

Arbitrates the single 256-entry memory port of the 8-bit core between three requesters: data access (LOAD/STORE), instruction fetch, and the debug/program loader. Grants one access per cycle, issues it to the synchronous memory, and returns read data one cycle later to the winner. Supports locked multi-beat sequences (read-modify-write, loader bursts) with a bounded lock length so no requester can starve the others.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: requester indices, memory arbiter state and default bus widths.
package cpu_pkg;

    localparam int unsigned REQ_DATA  = 0;
    localparam int unsigned REQ_FETCH = 1;
    localparam int unsigned REQ_DBG   = 2;

    localparam int unsigned CPU_AW = 8;
    localparam int unsigned CPU_DW = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-start priority picker: the first requester at or after start (wrapping) wins.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  pick_oh,
    output logic [IW-1:0] pick_idx,
    output logic          pick_valid
);

    logic [IW-1:0] cand;

    always_comb begin
        pick_oh    = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(start) + i) % N);
            if (!pick_valid && req[cand]) begin
                pick_valid    = 1'b1;
                pick_idx      = cand;
                pick_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single synchronous memory port, with bounded locked multi-beat sequences.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (data > fetch > debug).
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = CPU_AW,
    parameter int unsigned DW       = CPU_DW,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               lock_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    arb_state_t    state;
    logic [IW-1:0] owner;
    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] beat_cnt;
    logic [IW-1:0] start;
    logic [IW-1:0] win;
    logic [IW-1:0] pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic          pick_valid;
    logic          grant;
    logic          at_max;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req        (req),
        .start      (start),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // While locked only the owner can win; reset silences the port immediately.
    always_comb begin
        grant = 1'b0;
        win   = pick_idx;
        gnt   = '0;
        if (state == ARB_IDLE) begin
            grant = pick_valid;
            gnt   = pick_oh;
        end else begin
            win   = owner;
            grant = req[owner];
            gnt   = req[owner] ? (NREQ'(1) << owner) : '0;
        end
        if (!rst) begin
            grant = 1'b0;
            gnt   = '0;
        end
    end

    always_comb begin
        mem_en    = grant;
        mem_we    = grant & we[win];
        mem_addr  = grant ? addr[win*AW +: AW] : '0;
        mem_wdata = grant ? wdata[win*DW +: DW] : '0;
    end

    assign rdata = mem_rdata;

    // Beat count including the current beat, saturating at MAX_LOCK.
    assign beat_cnt = (state == ARB_IDLE)           ? CW'(1) :
                      (lock_cnt == CW'(MAX_LOCK))   ? lock_cnt :
                                                      lock_cnt + CW'(1);
    assign at_max   = (beat_cnt == CW'(MAX_LOCK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            lock_cnt <= '0;
            rvalid   <= '0;
            lock_err <= 1'b0;
        end else begin
            rvalid   <= (grant && !we[win]) ? gnt : '0;
            lock_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant && lock[win]) begin
                        owner    <= win;
                        lock_cnt <= CW'(1);
                        if (at_max) begin
                            lock_err <= 1'b1;
                        end else begin
                            state <= ARB_LOCKED;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (!grant) begin
                        state <= ARB_IDLE;
                    end else begin
                        lock_cnt <= beat_cnt;
                        if (at_max) begin
                            state    <= ARB_IDLE;
                            lock_err <= lock[win];
                        end else if (!lock[win]) begin
                            state <= ARB_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    // Pointer moves past every idle-state winner and past an owner whose lock timed out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant && (state == ARB_IDLE || at_max)) begin
            rr_ptr <= idx_inc(win);
        end
    end

    assign start = rr_ptr;
`else
    assign start = IW'(REQ_DATA);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors push per-cycle and read-return expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, we, lock;
    logic [23:0] addr, wdata;
    logic [2:0]  gnt, rvalid;
    logic [7:0]  rdata;
    logic        lock_err, mem_en, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem    [256];
    logic [7:0]  shadow [256];

    typedef struct packed {
        logic [2:0] gnt;
        logic       en;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [2:0] rv;
        logic       lerr;
        logic       in_rst;
    } cyc_t;

    cyc_t       cq[$];
    logic [7:0] rq[$];
    cyc_t       mc;
    logic [7:0] exp_rd;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .lock_err  (lock_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous memory: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cq.size() > 0) begin
            mc = cq.pop_front();
            chk("gnt", 8'(gnt), 8'(mc.gnt));
            chk("mem_en", 8'(mem_en), 8'(mc.en));
            chk("rvalid", 8'(rvalid), 8'(mc.rv));
            chk("lock_err", 8'(lock_err), 8'(mc.lerr));
            if (mc.en || mc.in_rst) begin
                chk("mem_we", 8'(mem_we), 8'(mc.we));
                chk("mem_addr", mem_addr, mc.addr);
            end
            if (mc.we || mc.in_rst) chk("mem_wdata", mem_wdata, mc.wdata);
        end
        if (rvalid != 3'b000) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 8'(rvalid), 8'h00);
            end else begin
                exp_rd = rq.pop_front();
                chk("rdata", rdata, exp_rd);
            end
        end
    end

    task automatic drv(input logic [1:0] i, input logic r, input logic w, input logic l,
                       input logic [7:0] a, input logic [7:0] d);
        req[i]  = r;
        we[i]   = w;
        lock[i] = l;
        addr[32'(i)*8 +: 8]  = a;
        wdata[32'(i)*8 +: 8] = d;
    endtask

    task automatic clr();
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    endtask

    // One cycle: expected grant, read-return strobe and lock_err for this cycle.
    task automatic step(input logic [2:0] eg, input logic [2:0] erv, input logic el);
        cyc_t c;
        c.gnt = eg; c.en = |eg; c.we = 1'b0; c.addr = '0; c.wdata = '0;
        c.rv = erv; c.lerr = el; c.in_rst = !rst;
        for (int i = 0; i < 3; i++) begin
            if (eg[2'(i)]) begin
                c.we    = we[2'(i)];
                c.addr  = addr[i*8 +: 8];
                c.wdata = wdata[i*8 +: 8];
            end
        end
        if (|eg) begin
            if (c.we) shadow[c.addr] = c.wdata;
            else      rq.push_back(shadow[c.addr]);
        end
        cq.push_back(c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g, prev;
        for (int a = 0; a < 256; a++) begin
            mem[a]   <= 8'(a) ^ 8'hA5;
            shadow[a] = 8'(a) ^ 8'hA5;
        end
        rst = 1'b0;
        clr();
        @(posedge clk);
        #1;

        // Requests during reset are ignored
        drv(0, 1, 1, 0, 8'h12, 8'h34);
        step(3'b000, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        rst = 1'b1;
        clr();
        step(3'b000, 3'b000, 1'b0);

        // All three reading, held 6 cycles
        drv(0, 1, 0, 0, 8'h20, 8'h00);
        drv(1, 1, 0, 0, 8'h21, 8'h00);
        drv(2, 1, 0, 0, 8'h22, 8'h00);
        prev = 3'b000;
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = 3'(3'b001 << (k % 3));
`else
            g = 3'b001;
`endif
            step(g, prev, 1'b0);
            prev = g;
        end
        clr();
        step(3'b000, prev, 1'b0);

        // Reset lands while a fetch read is in flight: its return is lost
        drv(1, 1, 0, 0, 8'h10, 8'h00);
        step(3'b010, 3'b000, 1'b0);
        void'(rq.pop_back());
        rst = 1'b0;
        step(3'b000, 3'b000, 1'b0);
        rst = 1'b1;
        clr();
        step(3'b000, 3'b000, 1'b0);

        // Data write then fetch read of the same location
        drv(0, 1, 1, 0, 8'hFE, 8'h5A);
        step(3'b001, 3'b000, 1'b0);
        drv(0, 0, 0, 0, 8'h00, 8'h00);
        drv(1, 1, 0, 0, 8'hFE, 8'h00);
        step(3'b010, 3'b000, 1'b0);
        clr();
        step(3'b000, 3'b010, 1'b0);

        // Loader 3-beat locked burst with fetch waiting
        drv(2, 1, 1, 1, 8'h40, 8'h11);
        step(3'b100, 3'b000, 1'b0);
        drv(1, 1, 0, 0, 8'h30, 8'h00);
        drv(2, 1, 1, 1, 8'h41, 8'h22);
        step(3'b100, 3'b000, 1'b0);
        drv(2, 1, 1, 0, 8'h42, 8'h33);
        step(3'b100, 3'b000, 1'b0);
        drv(2, 0, 0, 0, 8'h00, 8'h00);
        step(3'b010, 3'b000, 1'b0);
        clr();
        step(3'b000, 3'b010, 1'b0);

        // Loader holds lock past MAX_LOCK=8: forced release, fetch wins next
        drv(2, 1, 1, 1, 8'h50, 8'h01);
        step(3'b100, 3'b000, 1'b0);
        drv(1, 1, 0, 0, 8'h31, 8'h00);
        for (int k = 1; k < 8; k++) begin
            drv(2, 1, 1, 1, 8'(8'h50 + k), 8'(k + 1));
            step(3'b100, 3'b000, 1'b0);
        end
        drv(2, 1, 1, 1, 8'h58, 8'h09);
        step(3'b010, 3'b000, 1'b1);
        clr();
        step(3'b000, 3'b010, 1'b0);

        // Locked owner drops req: one bubble cycle, then fetch
        drv(2, 1, 1, 1, 8'h60, 8'h07);
        step(3'b100, 3'b000, 1'b0);
        drv(2, 0, 1, 1, 8'h61, 8'h08);
        drv(1, 1, 0, 0, 8'h32, 8'h00);
        step(3'b000, 3'b000, 1'b0);
        step(3'b010, 3'b000, 1'b0);
        clr();
        step(3'b000, 3'b010, 1'b0);

        // Read back loader data with back-to-back fetch grants
        drv(1, 1, 0, 0, 8'h42, 8'h00);
        step(3'b010, 3'b000, 1'b0);
        drv(1, 1, 0, 0, 8'h57, 8'h00);
        step(3'b010, 3'b010, 1'b0);
        clr();
        step(3'b000, 3'b010, 1'b0);
        step(3'b000, 3'b000, 1'b0);

        @(negedge clk);
        chk("cycle_queue_drained", 8'(cq.size()), 8'h00);
        chk("read_queue_drained", 8'(rq.size()), 8'h00);
        chk("readback_0x42", shadow[8'h42], 8'h33);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
